// File: rtl/tx_hdr_chksum_stage.sv
// TCP partial-checksum stage: ones'-complement sum over the IPv4 pseudo-header and the 20-byte TCP header.
// Optional feature macro TX_CHKSUM_OUT_FIFO_EN selects a 2-entry output FIFO instead of the HOLD register.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package tx_chksum_pkg;
  localparam int FLOWID_W_DEF  = 8;
  localparam int PAYLOAD_BUF_W = 64;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [15:0] off_flags;
    logic [15:0] window;
    logic [15:0] chksum;
    logic [15:0] urg_ptr;
  } tcp_hdr_struct;

  typedef struct packed {
    logic [47:0] buf_addr;
    logic [15:0] payload_len;
  } payload_buf_struct;

  function automatic logic [15:0] get_payload_len(input payload_buf_struct p);
    return p.payload_len;
  endfunction
endpackage

module tx_hdr_chksum_stage #(
  parameter int FLOWID_W  = tx_chksum_pkg::FLOWID_W_DEF,
  parameter int TCP_HDR_W = 160
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    src_chksum_tx_val,
  input  logic [FLOWID_W-1:0]                     src_chksum_tx_flowid,
  input  logic [`IP_ADDR_W-1:0]                   src_chksum_tx_src_ip,
  input  logic [`IP_ADDR_W-1:0]                   src_chksum_tx_dst_ip,
  input  logic [TCP_HDR_W-1:0]                    src_chksum_tx_tcp_hdr,
  input  logic [tx_chksum_pkg::PAYLOAD_BUF_W-1:0] src_chksum_tx_payload,
  output logic                                    chksum_src_tx_rdy,
  output logic                                    chksum_dst_tx_val,
  output logic [FLOWID_W-1:0]                     chksum_dst_tx_flowid,
  output logic [`IP_ADDR_W-1:0]                   chksum_dst_tx_src_ip,
  output logic [`IP_ADDR_W-1:0]                   chksum_dst_tx_dst_ip,
  output logic [TCP_HDR_W-1:0]                    chksum_dst_tx_tcp_hdr,
  output logic [tx_chksum_pkg::PAYLOAD_BUF_W-1:0] chksum_dst_tx_payload,
  input  logic                                    dst_chksum_tx_rdy
);
  localparam int PAY_W = tx_chksum_pkg::PAYLOAD_BUF_W;

  typedef enum logic [1:0] {IDLE, SUM, FOLD, HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   rdy_q, rdy_d, accept;
  logic [19:0]            acc_q, pair_sum;
  logic [2:0]             k_q;
  logic [FLOWID_W-1:0]    flowid_q;
  logic [`IP_ADDR_W-1:0]  src_ip_q, dst_ip_q;
  logic [TCP_HDR_W-1:0]   hdr_q;
  logic [PAY_W-1:0]       pay_q;
  logic [15:0]            pay_len;
  logic [15:0][15:0]      words;
  logic [16:0]            fold_t;
  logic [15:0]            fold_s;

  assign chksum_src_tx_rdy = rdy_q;
  assign accept            = src_chksum_tx_val && rdy_q && (state_q == IDLE);
  assign pay_len           = tx_chksum_pkg::get_payload_len(pay_q);

  // Pseudo-header then header words, MSB first; the checksum word counts as zero.
  always_comb begin
    words    = '0;
    words[0] = src_ip_q[31:16];
    words[1] = src_ip_q[15:0];
    words[2] = dst_ip_q[31:16];
    words[3] = dst_ip_q[15:0];
    words[4] = 16'h0006;
    words[5] = 16'd20 + pay_len;
    for (int i = 0; i < 10; i++)
      words[6+i] = (i == 8) ? 16'h0000 : hdr_q[TCP_HDR_W-1-16*i -: 16];
  end

  assign pair_sum = {4'b0, words[{k_q, 1'b0}]} + {4'b0, words[{k_q, 1'b1}]};
  assign fold_t   = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
  assign fold_s   = fold_t[15:0] + {15'b0, fold_t[16]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SUM;
      SUM:  if (k_q == 3'd7) state_d = FOLD;
`ifdef TX_CHKSUM_OUT_FIFO_EN
      FOLD: state_d = IDLE;
`else
      FOLD: state_d = HOLD;
`endif
      HOLD: if (dst_chksum_tx_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      flowid_q <= '0;
      src_ip_q <= '0;
      dst_ip_q <= '0;
      hdr_q    <= '0;
      pay_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      case (state_q)
        IDLE: if (accept) begin
          flowid_q <= src_chksum_tx_flowid;
          src_ip_q <= src_chksum_tx_src_ip;
          dst_ip_q <= src_chksum_tx_dst_ip;
          hdr_q    <= src_chksum_tx_tcp_hdr;
          pay_q    <= src_chksum_tx_payload;
          acc_q    <= '0;
          k_q      <= '0;
        end
        SUM: begin
          acc_q <= acc_q + pair_sum;
          k_q   <= k_q + 3'd1;
        end
        FOLD: hdr_q[31:16] <= fold_s;
        default: ;
      endcase
    end
  end

`ifndef TX_CHKSUM_OUT_FIFO_EN
  logic val_q;

  assign rdy_d = (state_d == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= 1'b0;
    else        val_q <= (state_d == HOLD);
  end

  assign chksum_dst_tx_val     = val_q;
  assign chksum_dst_tx_flowid  = flowid_q;
  assign chksum_dst_tx_src_ip  = src_ip_q;
  assign chksum_dst_tx_dst_ip  = dst_ip_q;
  assign chksum_dst_tx_tcp_hdr = hdr_q;
  assign chksum_dst_tx_payload = pay_q;
`else
  logic [1:0]                 cnt_q, cnt_d;
  logic                       wr_ptr_q, rd_ptr_q, push, pop, val_q;
  logic [1:0][FLOWID_W-1:0]   f_flowid;
  logic [1:0][`IP_ADDR_W-1:0] f_src_ip, f_dst_ip;
  logic [1:0][TCP_HDR_W-1:0]  f_hdr;
  logic [1:0][PAY_W-1:0]      f_pay;

  assign push  = (state_q == FOLD);
  assign pop   = val_q && dst_chksum_tx_rdy;
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  // Only IDLE may accept, so no descriptor is in flight when rdy is granted.
  assign rdy_d = (state_d == IDLE) && (cnt_d != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      val_q    <= 1'b0;
      f_flowid <= '0;
      f_src_ip <= '0;
      f_dst_ip <= '0;
      f_hdr    <= '0;
      f_pay    <= '0;
    end else begin
      if (push) begin
        f_flowid[wr_ptr_q] <= flowid_q;
        f_src_ip[wr_ptr_q] <= src_ip_q;
        f_dst_ip[wr_ptr_q] <= dst_ip_q;
        f_hdr[wr_ptr_q]    <= {hdr_q[TCP_HDR_W-1:32], fold_s, hdr_q[15:0]};
        f_pay[wr_ptr_q]    <= pay_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
      val_q <= (cnt_d != 2'd0);
    end
  end

  assign chksum_dst_tx_val     = val_q;
  assign chksum_dst_tx_flowid  = f_flowid[rd_ptr_q];
  assign chksum_dst_tx_src_ip  = f_src_ip[rd_ptr_q];
  assign chksum_dst_tx_dst_ip  = f_dst_ip[rd_ptr_q];
  assign chksum_dst_tx_tcp_hdr = f_hdr[rd_ptr_q];
  assign chksum_dst_tx_payload = f_pay[rd_ptr_q];
`endif

endmodule

// File: tb/tb_tx_hdr_chksum_stage.sv
// Bench for tx_hdr_chksum_stage: directed vector table, random descriptors vs a reference sum, backpressure and reset sequences.
module tb_tx_hdr_chksum_stage;
  import tx_chksum_pkg::*;

  localparam int FW = 8;
  localparam int HW = 160;
  localparam int PW = PAYLOAD_BUF_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          src_val = 1'b0;
  logic [FW-1:0] src_fid = '0;
  logic [31:0]   src_sip = '0, src_dip = '0;
  logic [HW-1:0] src_hdr = '0;
  logic [PW-1:0] src_pay = '0;
  logic          src_rdy;
  logic          dst_val;
  logic [FW-1:0] dst_fid;
  logic [31:0]   dst_sip, dst_dip;
  logic [HW-1:0] dst_hdr;
  logic [PW-1:0] dst_pay;
  logic          dst_rdy = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_hdr_chksum_stage #(.FLOWID_W(FW), .TCP_HDR_W(HW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .src_chksum_tx_val     (src_val),
    .src_chksum_tx_flowid  (src_fid),
    .src_chksum_tx_src_ip  (src_sip),
    .src_chksum_tx_dst_ip  (src_dip),
    .src_chksum_tx_tcp_hdr (src_hdr),
    .src_chksum_tx_payload (src_pay),
    .chksum_src_tx_rdy     (src_rdy),
    .chksum_dst_tx_val     (dst_val),
    .chksum_dst_tx_flowid  (dst_fid),
    .chksum_dst_tx_src_ip  (dst_sip),
    .chksum_dst_tx_dst_ip  (dst_dip),
    .chksum_dst_tx_tcp_hdr (dst_hdr),
    .chksum_dst_tx_payload (dst_pay),
    .dst_chksum_tx_rdy     (dst_rdy)
  );

  typedef struct {
    logic [FW-1:0] fid;
    logic [31:0]   sip;
    logic [31:0]   dip;
    logic [HW-1:0] hdr;
    logic [PW-1:0] pay;
  } desc_t;

  typedef struct {
    desc_t       d;
    logic [15:0] exp_chk;
  } vec_t;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic desc_t mk(input logic [FW-1:0] fid, input logic [31:0] sip, input logic [31:0] dip,
                               input logic [HW-1:0] hdr, input logic [PW-1:0] pay);
    desc_t d;
    d.fid = fid; d.sip = sip; d.dip = dip; d.hdr = hdr; d.pay = pay;
    return d;
  endfunction

  // Reference: plain integer sum of all 16-bit words, then end-around carry until it fits.
  function automatic logic [15:0] ref_chk(input desc_t d);
    int unsigned s;
    s = d.sip[31:16] + d.sip[15:0] + d.dip[31:16] + d.dip[15:0] + 6 + ((20 + d.pay[15:0]) % 65536);
    for (int i = 0; i < 10; i++)
      if (i != 8) s += d.hdr[159-16*i -: 16];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic logic [HW-1:0] with_chk(input logic [HW-1:0] h, input logic [15:0] c);
    logic [HW-1:0] r;
    r = h;
    r[31:16] = c;
    return r;
  endfunction

  task automatic send(input desc_t d, input string tag);
    int n;
    n = 0;
    while (!src_rdy && n < 100) begin @(negedge clk); n++; end
    check({tag, "_src_rdy"}, src_rdy, 1'b1);
    src_fid = d.fid; src_sip = d.sip; src_dip = d.dip; src_hdr = d.hdr; src_pay = d.pay;
    src_val = 1'b1;
    @(negedge clk);
    src_val = 1'b0;
    src_fid = FW'($urandom); src_sip = $urandom; src_dip = $urandom;
    src_hdr = {$urandom, $urandom, $urandom, $urandom, $urandom};
    src_pay = {$urandom, $urandom};
  endtask

  // Called at the first negedge after the accepting edge (cycle 1).
  task automatic expect_out(input desc_t d, input logic [15:0] chk, input int exp_lat,
                            input bit last, input string tag);
    int lat;
    lat = 1;
    while (!dst_val && lat < 40) begin @(negedge clk); lat++; end
    check({tag, "_val"}, dst_val, 1'b1);
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_chk"}, dst_hdr[31:16], chk);
    check({tag, "_hdr"}, dst_hdr, with_chk(d.hdr, chk));
    check({tag, "_pass"}, {dst_fid, dst_sip, dst_dip, dst_pay}, {d.fid, d.sip, d.dip, d.pay});
    @(negedge clk);
    if (last) begin
      check({tag, "_val_drop"}, dst_val, 1'b0);
      check({tag, "_rdy_back"}, src_rdy, 1'b1);
    end
  endtask

  vec_t  vecs[5];
  desc_t d, a, b;
  logic [15:0] c;

  initial begin
    vecs[0].d = mk('0, 32'h0, 32'h0, '0, '0);                                       vecs[0].exp_chk = 16'h001A;
    vecs[1].d = mk('0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0);                       vecs[1].exp_chk = 16'h001A;
    vecs[2].d = mk(8'hA5, 32'h0, 32'h0, 160'h0000_BEEF_0000, 64'h1234_5678_9ABC_0000); vecs[2].exp_chk = 16'h001A;
    vecs[3].d = mk('0, 32'h0, 32'h0, '0, 64'h0000_0000_0000_FFF0);                  vecs[3].exp_chk = 16'h000A;
    vecs[4].d = mk(8'h3C, 32'h0A00_0001, 32'h0A00_0002, {16'h1234, 16'h0050, 128'h0}, '0);
    vecs[4].exp_chk = 16'h26A1;

    repeat (3) @(negedge clk);
    check("reset_rdy", src_rdy, 1'b0);
    check("reset_val", dst_val, 1'b0);
    check("reset_data", {dst_fid, dst_sip, dst_dip, dst_pay}, '0);
    check("reset_hdr", dst_hdr, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_rdy", src_rdy, 1'b1);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].d, $sformatf("vec%0d", i));
      expect_out(vecs[i].d, vecs[i].exp_chk, 10, 1'b1, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      d = mk(FW'($urandom), $urandom, $urandom,
             {$urandom, $urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
      if (i % 4 == 0) d.pay[15:0] = 16'hFFEC + 16'($urandom_range(0, 40));
      if (i % 5 == 1) begin d.sip = 32'hFFFF_FFFF; d.dip = 32'hFFFF_FFFF; end
      send(d, $sformatf("rnd%0d", i));
      expect_out(d, ref_chk(d), 10, 1'b1, $sformatf("rnd%0d", i));
    end

    // Backpressure: outputs held and src rdy low while downstream stalls.
    a = mk(8'h11, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
    b = mk(8'h22, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
    dst_rdy = 1'b0;
    send(a, "bp_a");
    repeat (10) @(negedge clk);
`ifdef TX_CHKSUM_OUT_FIFO_EN
    send(b, "bp_b");
    repeat (12) @(negedge clk);
`endif
    c = ref_chk(a);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp_hold_val%0d", i), dst_val, 1'b1);
      check($sformatf("bp_hold_hdr%0d", i), dst_hdr, with_chk(a.hdr, c));
      check($sformatf("bp_hold_rdy%0d", i), src_rdy, 1'b0);
      @(negedge clk);
    end
    dst_rdy = 1'b1;
`ifdef TX_CHKSUM_OUT_FIFO_EN
    expect_out(a, c, -1, 1'b0, "bp_out_a");
    expect_out(b, ref_chk(b), -1, 1'b1, "bp_out_b");
`else
    expect_out(a, c, -1, 1'b1, "bp_out_a");
    send(b, "bp_b");
    expect_out(b, ref_chk(b), 10, 1'b1, "bp_out_b");
`endif

    // Reset in the middle of SUM, then a clean descriptor must not see stale state.
    send(vecs[1].d, "mid_rst");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", dst_val, 1'b0);
    check("mid_rst_rdy", src_rdy, 1'b0);
    check("mid_rst_hdr", dst_hdr, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst_rdy_low%0d", i), src_rdy, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy_after", src_rdy, 1'b1);
    check("mid_rst_val_after", dst_val, 1'b0);
    send(vecs[0].d, "post_rst");
    expect_out(vecs[0].d, 16'h001A, 10, 1'b1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
